// File: rtl/hazard_stall_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_stall_controller: RAW interlock for a 5-stage pipeline. Tracks
// EX/MEM/WB destinations and stalls PC/IF-ID with an ID/EX bubble on conflict.
// Revision: 1.0
// ---------------------------------------------------------------------------
module hazard_stall_controller #(
   parameter int DEPTH = 3,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      instr_id,
   input  logic             id_valid,
   input  logic             flush,
   input  logic             hold,
   input  logic             cnt_clr,
   output logic             pc_write_en,
   output logic             ifid_write_en,
   output logic             idex_bubble,
   output logic             hazard,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [5:0] OP_ALU_RR  = 6'b010100;
   localparam logic [5:0] OP_ALU_I0  = 6'b101001;
   localparam logic [5:0] OP_ALU_I1  = 6'b101010;
   localparam logic [5:0] OP_LOAD    = 6'b100111;
   localparam logic [5:0] OP_STORE   = 6'b101000;

   logic [5:0] op;
   logic [4:0] rs, rt, rd;
   logic       use_rs, use_rt, writes;
   logic [4:0] dst;
   logic       unused_funct;

   logic [DEPTH-1:0] sb_v_q, sb_v_d;
   logic [4:0]       sb_dst_q [DEPTH];
   logic [4:0]       sb_dst_d [DEPTH];
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   logic raw;
   logic shift_en, ins_v, cnt_inc;
   logic pc_en, ifid_en, bubble;

   assign op           = instr_id[31:26];
   assign rs           = instr_id[25:21];
   assign rt           = instr_id[20:16];
   assign rd           = instr_id[15:11];
   assign unused_funct = ^instr_id[10:0];

   always_comb begin
      use_rs = 1'b0;
      use_rt = 1'b0;
      writes = 1'b0;
      dst    = rd;
      case (op)
         OP_ALU_RR: begin use_rs = 1'b1; use_rt = 1'b1; writes = 1'b1; dst = rd; end
         OP_ALU_I0,
         OP_ALU_I1,
         OP_LOAD:   begin use_rs = 1'b1; writes = 1'b1; dst = rt; end
         OP_STORE:  begin use_rs = 1'b1; use_rt = 1'b1; end
         default:   ;
      endcase
   end

   // r0 is hardwired, so a read of it can never depend on anything in flight
   always_comb begin
      raw = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (sb_v_q[i] &&
             ((use_rs && (rs != 5'd0) && (rs == sb_dst_q[i])) ||
              (use_rt && (rt != 5'd0) && (rt == sb_dst_q[i]))))
            raw = 1'b1;
      end
      raw = raw & id_valid;
   end

   always_comb begin
      shift_en = 1'b1;
      ins_v    = 1'b0;
      cnt_inc  = 1'b0;
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      bubble   = 1'b0;
      if (hold) begin
         shift_en = 1'b0;
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
      end else if (flush) begin
         bubble   = 1'b1;
      end else if (raw) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         bubble   = 1'b1;
         cnt_inc  = 1'b1;
      end else begin
         ins_v    = writes & (dst != 5'd0) & id_valid;
      end
   end

   always_comb begin
      sb_v_d   = sb_v_q;
      sb_dst_d = sb_dst_q;
      if (shift_en) begin
         sb_v_d[0]   = ins_v;
         sb_dst_d[0] = dst;
         for (int i = 1; i < DEPTH; i++) begin
            sb_v_d[i]   = sb_v_q[i-1];
            sb_dst_d[i] = sb_dst_q[i-1];
         end
      end
   end

   always_comb begin
      stall_count_d = stall_count_q;
      if (cnt_clr)
         stall_count_d = '0;
      else if (cnt_inc && (stall_count_q != '1))
         stall_count_d = stall_count_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_v_q        <= '0;
         stall_count_q <= '0;
         for (int i = 0; i < DEPTH; i++) sb_dst_q[i] <= 5'd0;
      end else begin
         sb_v_q        <= sb_v_d;
         sb_dst_q      <= sb_dst_d;
         stall_count_q <= stall_count_d;
      end
   end

   // While reset is asserted the pipeline is held with a bubble in ID/EX
   assign pc_write_en   = rst_n & pc_en;
   assign ifid_write_en = rst_n & ifid_en;
   assign idex_bubble   = ~rst_n | bubble;
   assign hazard        = rst_n & raw;
   assign stall_count   = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hazard_stall_controller: scenario tasks with an expected-result queue.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_hazard_stall_controller;

   localparam int DEPTH = 3;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [31:0]      instr_id = '0;
   logic             id_valid = 1'b0;
   logic             flush = 1'b0;
   logic             hold = 1'b0;
   logic             cnt_clr = 1'b0;
   logic             pc_write_en, ifid_write_en, idex_bubble, hazard;
   logic [CNT_W-1:0] stall_count;

   hazard_stall_controller #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .instr_id(instr_id), .id_valid(id_valid),
      .flush(flush), .hold(hold), .cnt_clr(cnt_clr),
      .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
      .idex_bubble(idex_bubble), .hazard(hazard), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] P11 = {6'b010100, 5'd12, 5'd13, 5'd11, 5'd0, 6'b011011};
   localparam logic [31:0] C11 = {6'b010100, 5'd11, 5'd15, 5'd13, 5'd0, 6'b100100};
   localparam logic [31:0] PX  = {6'b010100, 5'd1,  5'd2,  5'd11, 11'd0};
   localparam logic [31:0] IND = {6'b010100, 5'd1,  5'd2,  5'd3,  11'd0};
   localparam logic [31:0] L1  = {6'b100111, 5'd20, 5'd21, 16'h0040};
   localparam logic [31:0] L2  = {6'b100111, 5'd21, 5'd22, 16'h0000};
   localparam logic [31:0] W0  = {6'b010100, 5'd1,  5'd2,  5'd0,  11'd0};
   localparam logic [31:0] R0  = {6'b010100, 5'd0,  5'd0,  5'd4,  11'd0};
   localparam logic [31:0] NOP = 32'h0;

   typedef struct packed {
      logic [31:0]      ins;
      logic             v, fl, hd, clr, rn;
      logic [3:0]       e;     // {pc_write_en, ifid_write_en, idex_bubble, hazard}
      logic [CNT_W-1:0] c;     // stall_count seen during this step
   } step_t;

   logic [3:0]       exp_q [$];
   logic [CNT_W-1:0] cnt_q [$];
   int errors = 0;
   int checks = 0;

   function automatic step_t mk(logic [31:0] ins, logic v, logic fl, logic hd,
                                logic clr, logic rn, logic [3:0] e, int c);
      step_t s;
      s.ins = ins; s.v = v; s.fl = fl; s.hd = hd; s.clr = clr; s.rn = rn;
      s.e = e; s.c = CNT_W'(c);
      return s;
   endfunction

   function automatic int sat(int m);
      return (m > 15) ? 15 : m;
   endfunction

   task automatic apply(input step_t s);
      @(negedge clk);
      instr_id = s.ins; id_valid = s.v; flush = s.fl; hold = s.hd;
      cnt_clr = s.clr; rst_n = s.rn;
      exp_q.push_back(s.e);
      cnt_q.push_back(s.c);
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; instr_id = '0; id_valid = 1'b0;
      flush = 1'b0; hold = 1'b0; cnt_clr = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      step_t s[$];
      logic [3:0] got, e;
      logic [CNT_W-1:0] ec;
      s.push_back(mk(C11, 1, 0, 0, 0, 0, 4'b0010, 0));
      s.push_back(mk(C11, 1, 0, 0, 0, 0, 4'b0010, 0));
      s.push_back(mk(C11, 1, 0, 0, 0, 1, 4'b1100, 0));
      foreach (s[i]) begin
         apply(s[i]);
         got = {pc_write_en, ifid_write_en, idex_bubble, hazard};
         e = exp_q.pop_front(); ec = cnt_q.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL reset[%0d] ctl got=%b exp=%b", i, got, e); end
         checks++;
         if (stall_count !== ec) begin errors++; $display("FAIL reset[%0d] count got=%0d exp=%0d", i, stall_count, ec); end
      end
   endtask

   task automatic test_back_to_back();
      step_t s[$];
      logic [3:0] got, e;
      logic [CNT_W-1:0] ec;
      do_reset();
      s.push_back(mk(P11, 1, 0, 0, 0, 1, 4'b1100, 0));
      s.push_back(mk(C11, 1, 0, 0, 0, 1, 4'b0011, 0));
      s.push_back(mk(C11, 1, 0, 0, 0, 1, 4'b0011, 1));
      s.push_back(mk(C11, 1, 0, 0, 0, 1, 4'b0011, 2));
      s.push_back(mk(C11, 1, 0, 0, 0, 1, 4'b1100, 3));
      s.push_back(mk(NOP, 1, 0, 0, 0, 1, 4'b1100, 3));
      foreach (s[i]) begin
         apply(s[i]);
         got = {pc_write_en, ifid_write_en, idex_bubble, hazard};
         e = exp_q.pop_front(); ec = cnt_q.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL b2b[%0d] ctl got=%b exp=%b", i, got, e); end
         checks++;
         if (stall_count !== ec) begin errors++; $display("FAIL b2b[%0d] count got=%0d exp=%0d", i, stall_count, ec); end
      end
   endtask

   task automatic test_distance();
      step_t s[$];
      logic [3:0] got, e;
      logic [CNT_W-1:0] ec;
      do_reset();
      s.push_back(mk(L1,  1, 0, 0, 0, 1, 4'b1100, 0));
      s.push_back(mk(NOP, 1, 0, 0, 0, 1, 4'b1100, 0));
      s.push_back(mk(NOP, 1, 0, 0, 0, 1, 4'b1100, 0));
      s.push_back(mk(L2,  1, 0, 0, 0, 1, 4'b0011, 0));
      s.push_back(mk(L2,  1, 0, 0, 0, 1, 4'b1100, 1));
      s.push_back(mk(L1,  1, 0, 0, 0, 1, 4'b1100, 1));
      s.push_back(mk(NOP, 1, 0, 0, 0, 1, 4'b1100, 1));
      s.push_back(mk(NOP, 1, 0, 0, 0, 1, 4'b1100, 1));
      s.push_back(mk(NOP, 1, 0, 0, 0, 1, 4'b1100, 1));
      s.push_back(mk(L2,  1, 0, 0, 0, 1, 4'b1100, 1));
      s.push_back(mk(NOP, 1, 0, 0, 0, 1, 4'b1100, 1));
      foreach (s[i]) begin
         apply(s[i]);
         got = {pc_write_en, ifid_write_en, idex_bubble, hazard};
         e = exp_q.pop_front(); ec = cnt_q.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL distance[%0d] ctl got=%b exp=%b", i, got, e); end
         checks++;
         if (stall_count !== ec) begin errors++; $display("FAIL distance[%0d] count got=%0d exp=%0d", i, stall_count, ec); end
      end
   endtask

   task automatic test_r0_and_invalid();
      step_t s[$];
      logic [3:0] got, e;
      logic [CNT_W-1:0] ec;
      do_reset();
      s.push_back(mk(W0,  1, 0, 0, 0, 1, 4'b1100, 0));
      s.push_back(mk(R0,  1, 0, 0, 0, 1, 4'b1100, 0));
      s.push_back(mk(P11, 1, 0, 0, 0, 1, 4'b1100, 0));
      s.push_back(mk(C11, 0, 0, 0, 0, 1, 4'b1100, 0));
      s.push_back(mk(C11, 1, 0, 0, 0, 1, 4'b0011, 0));
      s.push_back(mk(C11, 1, 0, 0, 0, 1, 4'b0011, 1));
      s.push_back(mk(C11, 1, 0, 0, 0, 1, 4'b1100, 2));
      foreach (s[i]) begin
         apply(s[i]);
         got = {pc_write_en, ifid_write_en, idex_bubble, hazard};
         e = exp_q.pop_front(); ec = cnt_q.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL r0[%0d] ctl got=%b exp=%b", i, got, e); end
         checks++;
         if (stall_count !== ec) begin errors++; $display("FAIL r0[%0d] count got=%0d exp=%0d", i, stall_count, ec); end
      end
   endtask

   task automatic test_hold();
      step_t s[$];
      logic [3:0] got, e;
      logic [CNT_W-1:0] ec;
      do_reset();
      s.push_back(mk(P11, 1, 0, 0, 0, 1, 4'b1100, 0));
      s.push_back(mk(C11, 1, 0, 0, 0, 1, 4'b0011, 0));
      s.push_back(mk(C11, 1, 0, 1, 0, 1, 4'b0001, 1));
      s.push_back(mk(C11, 1, 0, 1, 0, 1, 4'b0001, 1));
      s.push_back(mk(C11, 1, 0, 0, 0, 1, 4'b0011, 1));
      s.push_back(mk(C11, 1, 0, 0, 0, 1, 4'b0011, 2));
      s.push_back(mk(C11, 1, 0, 0, 0, 1, 4'b1100, 3));
      foreach (s[i]) begin
         apply(s[i]);
         got = {pc_write_en, ifid_write_en, idex_bubble, hazard};
         e = exp_q.pop_front(); ec = cnt_q.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL hold[%0d] ctl got=%b exp=%b", i, got, e); end
         checks++;
         if (stall_count !== ec) begin errors++; $display("FAIL hold[%0d] count got=%0d exp=%0d", i, stall_count, ec); end
      end
   endtask

   task automatic test_flush();
      step_t s[$];
      logic [3:0] got, e;
      logic [CNT_W-1:0] ec;
      do_reset();
      s.push_back(mk(P11, 1, 0, 0, 0, 1, 4'b1100, 0));
      s.push_back(mk(C11, 1, 0, 0, 0, 1, 4'b0011, 0));
      s.push_back(mk(C11, 1, 1, 0, 0, 1, 4'b1111, 1));
      s.push_back(mk(IND, 1, 0, 0, 0, 1, 4'b1100, 1));
      s.push_back(mk(NOP, 1, 0, 0, 0, 1, 4'b1100, 1));
      foreach (s[i]) begin
         apply(s[i]);
         got = {pc_write_en, ifid_write_en, idex_bubble, hazard};
         e = exp_q.pop_front(); ec = cnt_q.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL flush[%0d] ctl got=%b exp=%b", i, got, e); end
         checks++;
         if (stall_count !== ec) begin errors++; $display("FAIL flush[%0d] count got=%0d exp=%0d", i, stall_count, ec); end
      end
   endtask

   task automatic test_saturate_clear_reset();
      step_t s[$];
      logic [3:0] got, e;
      logic [CNT_W-1:0] ec;
      int m = 0;
      do_reset();
      for (int k = 0; k < 6; k++) begin
         s.push_back(mk(PX, 1, 0, 0, 0, 1, 4'b1100, sat(m)));
         for (int j = 0; j < 3; j++) begin
            s.push_back(mk(C11, 1, 0, 0, 0, 1, 4'b0011, sat(m)));
            m++;
         end
         s.push_back(mk(C11, 1, 0, 0, 0, 1, 4'b1100, sat(m)));
      end
      s.push_back(mk(PX,  1, 0, 0, 0, 1, 4'b1100, 15));
      s.push_back(mk(C11, 1, 0, 0, 1, 1, 4'b0011, 15));
      s.push_back(mk(C11, 1, 0, 0, 0, 1, 4'b0011, 0));
      s.push_back(mk(C11, 1, 0, 1, 1, 1, 4'b0001, 1));
      s.push_back(mk(C11, 1, 0, 0, 0, 1, 4'b0011, 0));
      s.push_back(mk(C11, 1, 0, 0, 0, 1, 4'b1100, 1));
      s.push_back(mk(PX,  1, 0, 0, 0, 1, 4'b1100, 1));
      s.push_back(mk(C11, 1, 0, 0, 0, 1, 4'b0011, 1));
      s.push_back(mk(C11, 1, 0, 0, 0, 0, 4'b0010, 0));
      s.push_back(mk(C11, 1, 0, 0, 0, 1, 4'b1100, 0));
      foreach (s[i]) begin
         apply(s[i]);
         got = {pc_write_en, ifid_write_en, idex_bubble, hazard};
         e = exp_q.pop_front(); ec = cnt_q.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL satclr[%0d] ctl got=%b exp=%b", i, got, e); end
         checks++;
         if (stall_count !== ec) begin errors++; $display("FAIL satclr[%0d] count got=%0d exp=%0d", i, stall_count, ec); end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_back_to_back();
      test_distance();
      test_r0_and_invalid();
      test_hold();
      test_flush();
      test_saturate_clear_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Interlock unit for the 5-stage pipeline (IF, ID, EX, MEM, WB). It removes the need for hand-inserted all-zero NOPs in program images.
- Decodes the instruction in IF/ID and tracks destination registers of instructions in EX, MEM and WB in an internal scoreboard.
- On a read-after-write hazard it freezes PC and IF/ID and injects a bubble into ID/EX.
- Drives the PC-enable, IF/ID-enable and ID/EX-bubble controls and keeps a stall-cycle counter.

Parameters:
- DEPTH, 3, scoreboard entries (EX, MEM, WB). There is no register-file bypass, so WB conflicts too.
- CNT_W, 16, width of stall_count.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_id  in  32  instruction in IF/ID
- id_valid  in  1  instr_id holds a real instruction (0 = treat as NOP)
- flush  in  1  squash the instruction in ID (taken branch/redirect)
- hold  in  1  global pipeline freeze (e.g. memory not ready)
- cnt_clr  in  1  synchronous clear of stall_count
- pc_write_en  out  1  PC may advance
- ifid_write_en  out  1  IF/ID may load
- idex_bubble  out  1  load all-zero NOP into ID/EX
- hazard  out  1  RAW hazard detected this cycle (before priority)
- stall_count  out  CNT_W  saturating count of hazard stall cycles

Behaviour:
- Field decode: op = [31:26], rs = [25:21], rt = [20:16], rd = [15:11].
  - 010100: reads rs, rt; writes rd.
  - 101001, 101010 (immediate ALU): read rs; write rt.
  - 100111 (load): reads rs; writes rt.
  - 101000 (store): reads rs, rt; no write.
  - 000000 and all other opcodes: no read, no write.
- Register 0 is never a hazard source. Writes to r0 enter the scoreboard as invalid.
- Scoreboard: DEPTH entries {v, dst[4:0]}, entry0 = EX ... entry DEPTH-1 = WB.
- hazard: combinational. Equals id_valid AND some used source == dst of some valid entry.
- Priority and outputs, same cycle, no latency:
  - hold=1: pc_write_en=0, ifid_write_en=0, idex_bubble=0. Scoreboard does not shift; counter unchanged.
  - else flush=1: pc_write_en=1, ifid_write_en=1, idex_bubble=1. Scoreboard shifts, inserting invalid. No count.
  - else hazard=1: pc_write_en=0, ifid_write_en=0, idex_bubble=1. Scoreboard shifts, inserting invalid. stall_count +1.
  - else: pc_write_en=1, ifid_write_en=1, idex_bubble=0. Scoreboard shifts, inserting {writes & dst!=0 & id_valid, dst}.
- Shift: entry[i+1] <= entry[i]. The WB entry is discarded.
- Back-to-back dependency costs exactly DEPTH stall cycles. Distance k (1..DEPTH) costs DEPTH-k+1. Distance > DEPTH costs 0.
- Multiple matches cost no extra stalls; the youngest match governs clearance naturally.
- stall_count:
  - Saturates at all-ones.
  - cnt_clr wins over increment (result 0) and applies even during hold.
- Reset (rst_n low, async):
  - All scoreboard v=0; stall_count=0.
  - Outputs forced pc_write_en=0, ifid_write_en=0, idex_bubble=1, hazard=0 while rst_n low.
  - First post-reset cycle: no hazards possible.
- Reset mid-stall: scoreboard cleared immediately. The pending consumer issues on the first cycle after release.
- flush during hazard: flush wins, no stall counted, the consumer is discarded.

Test Plan:
- Reset, then instr_id=010100_01100_01101_01011_00000_011011 followed by 010100_01011_01111_01101_00000_100100 -> hazard on r11. idex_bubble=1 and pc_write_en=0 for 3 cycles, then the consumer issues; stall_count=3.
- Load 100111 rs=r20 rt=r21, then 2 NOPs, then 100111 rs=r21 -> exactly 1 stall cycle. With 3 intervening NOPs -> 0 stalls.
- Producer writing r0 (010100 ... rd=00000), then consumer reading r0 -> no stall; hazard=0.
- Hazard active, then hold=1 for 2 cycles -> all enables 0, idex_bubble=0, stall_count frozen. After hold drops, remaining stall cycles still total 3.
- Hazard active, flush=1 for 1 cycle -> idex_bubble=1, pc_write_en=1, stall_count unchanged. Next non-dependent instruction issues with no stall.
- Preload stall_count to all-ones via 2^CNT_W-1 hazard cycles (or CNT_W=4) -> saturates. cnt_clr=1 during a hazard -> 0. Assert rst_n=0 mid-stall -> scoreboard empty, count 0.
